// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the
// instruction-fetch port (I) and the load/store port (D) of the core.
//
// Only one read may be outstanding. Stores complete in their grant cycle.
// Read data comes back a fixed LAT cycles after the read is accepted.
// LAT must lie in 1..15 so that it fits the 4-bit latency counter.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no read outstanding; memory can accept an access
//   S_WAIT | read outstanding; cnt_q counts down to the data cycle,
//          | and the cycle with cnt_q == 1 is the return cycle (ready)
module mem_port_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int INSTR_W   = 32,
    parameter int MEMTYPE_W = 3,
    parameter int LAT       = 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [INSTR_W-1:0]   i_rdata,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [MEMTYPE_W-1:0] d_type,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DATA_W-1:0]    d_rdata,

    output logic                 m_req,
    output logic                 m_we,
    output logic [MEMTYPE_W-1:0] m_type,
    output logic [ADDR_W-1:0]    m_addr,
    output logic [DATA_W-1:0]    m_wdata,
    input  logic [DATA_W-1:0]    m_rdata
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0]           LAT_CNT   = 4'(LAT);
    localparam logic [MEMTYPE_W-1:0] WORD_TYPE = 3'b010;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // owner_q: 0 = I, 1 = D (port whose read is outstanding)
    logic       owner_q, owner_d;
    // rr_q records which port was granted last, encoded as 1 = I and 0 = D.
    // Resetting it to 1 therefore makes D win the first tie after reset.
    logic       rr_q, rr_d;

    logic       ret_cyc;
    logic       ready;
    logic       rd_gnt;

    assign ret_cyc = (state_q == S_WAIT) && (cnt_q == 4'd1);
    assign ready   = (state_q == S_IDLE) || ret_cyc;

    // Round-robin arbitration; grants are forced low while reset is asserted
    // so nothing reaches the memory during reset.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset && ready) begin
            if (i_req && d_req) begin
                d_gnt = rr_q;
                i_gnt = !rr_q;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    assign rd_gnt = i_gnt || (d_gnt && !d_we);

    // Memory request mux: zero on the bus whenever nothing is granted.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_type  = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_req   = 1'b1;
            m_we    = d_we;
            m_type  = d_type;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (i_gnt) begin
            m_req   = 1'b1;
            m_we    = 1'b0;
            m_type  = WORD_TYPE;
            m_addr  = i_addr;
            m_wdata = d_wdata;
        end
    end

    // Read return: data path is combinational, qualified by the owner's rvalid.
    assign i_rvalid = ret_cyc && !owner_q;
    assign d_rvalid = ret_cyc && owner_q;
    assign i_rdata  = m_rdata[INSTR_W-1:0];
    assign d_rdata  = m_rdata;

    // Next-state: a read grant (even in the return cycle) reloads the
    // latency counter; otherwise WAIT counts down and drops back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (i_gnt || d_gnt) begin
            rr_d = i_gnt;
        end
        if (rd_gnt) begin
            state_d = S_WAIT;
            cnt_d   = LAT_CNT;
            owner_d = d_gnt;
        end else if (state_q == S_WAIT) begin
            if (ret_cyc) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // State registers; reset discards any outstanding read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=1 and LAT=3) share clock and
// reset. A transaction-level model (due cycle of the outstanding read, last
// granted port, memory contents) predicts every output each cycle.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 32;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          i_req   [2];
    logic [AW-1:0] i_addr  [2];
    logic          i_gnt   [2];
    logic          i_rvalid[2];
    logic [IW-1:0] i_rdata [2];
    logic          d_req   [2];
    logic          d_we    [2];
    logic [TW-1:0] d_type  [2];
    logic [AW-1:0] d_addr  [2];
    logic [DW-1:0] d_wdata [2];
    logic          d_gnt   [2];
    logic          d_rvalid[2];
    logic [DW-1:0] d_rdata [2];
    logic          m_req   [2];
    logic          m_we    [2];
    logic [TW-1:0] m_type  [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(.LAT(k == 0 ? 1 : 3)) u_dut (
            .clk(clk), .reset(reset),
            .i_req(i_req[k]), .i_addr(i_addr[k]), .i_gnt(i_gnt[k]),
            .i_rvalid(i_rvalid[k]), .i_rdata(i_rdata[k]),
            .d_req(d_req[k]), .d_we(d_we[k]), .d_type(d_type[k]),
            .d_addr(d_addr[k]), .d_wdata(d_wdata[k]), .d_gnt(d_gnt[k]),
            .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]),
            .m_req(m_req[k]), .m_we(m_we[k]), .m_type(m_type[k]),
            .m_addr(m_addr[k]), .m_wdata(m_wdata[k]), .m_rdata(m_rdata[k])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int            due      [2] = '{-1, -1};
    bit            due_port [2] = '{1'b0, 1'b0};   // 0 = I, 1 = D
    logic [DW-1:0] due_data [2];
    bit            last_d   [2] = '{1'b0, 1'b0};   // D granted last
    logic [DW-1:0] mem [logic [AW:0]];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] memval(input int k, input logic [AW-1:0] a);
        logic [AW:0] key;
        key = {k[0], a};
        if (mem.exists(key)) return mem[key];
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                chk("rst_flags", k, {i_gnt[k], d_gnt[k], i_rvalid[k], d_rvalid[k],
                                     m_req[k], m_we[k]}, 64'd0);
                chk("rst_m_type", k, m_type[k], 64'd0);
                chk("rst_m_addr", k, m_addr[k], 64'd0);
                chk("rst_m_wdata", k, m_wdata[k], 64'd0);
                due[k] = -1;
                last_d[k] = 1'b0;
            end else begin
                bit rdy, eg_i, eg_d, rv_i, rv_d, ereq, ewe;
                logic [TW-1:0] etype;
                logic [AW-1:0] eaddr;
                logic [DW-1:0] ewd;
                rdy  = (due[k] < 0) || (due[k] == cyc);
                eg_d = rdy && d_req[k] && (!i_req[k] || !last_d[k]);
                eg_i = rdy && i_req[k] && (!d_req[k] || last_d[k]);
                rv_i = (due[k] == cyc) && !due_port[k];
                rv_d = (due[k] == cyc) && due_port[k];
                ereq = eg_i || eg_d;
                ewe = 1'b0; etype = '0; eaddr = '0; ewd = '0;
                if (eg_d) begin
                    ewe = d_we[k]; etype = d_type[k]; eaddr = d_addr[k]; ewd = d_wdata[k];
                end else if (eg_i) begin
                    etype = 3'b010; eaddr = i_addr[k]; ewd = d_wdata[k];
                end
                chk("i_gnt", k, i_gnt[k], eg_i);
                chk("d_gnt", k, d_gnt[k], eg_d);
                chk("m_req", k, m_req[k], ereq);
                chk("m_we", k, m_we[k], ewe);
                chk("m_type", k, m_type[k], etype);
                chk("m_addr", k, m_addr[k], eaddr);
                chk("m_wdata", k, m_wdata[k], ewd);
                chk("i_rvalid", k, i_rvalid[k], rv_i);
                chk("d_rvalid", k, d_rvalid[k], rv_d);
                if (rv_i) chk("i_rdata", k, i_rdata[k], due_data[k][IW-1:0]);
                if (rv_d) chk("d_rdata", k, d_rdata[k], due_data[k]);
                if (ereq) last_d[k] = eg_d;
                if (eg_d && d_we[k]) mem[{k[0], d_addr[k]}] = d_wdata[k];
                if (eg_i || (eg_d && !d_we[k])) begin
                    due[k] = cyc + lat_of(k);
                    due_port[k] = eg_d;
                    due_data[k] = memval(k, eg_d ? d_addr[k] : i_addr[k]);
                end else if (due[k] == cyc) begin
                    due[k] = -1;
                end
            end
        end
    end

    // Memory side: the read word appears exactly in the return cycle,
    // unrelated noise at all other times.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++)
            m_rdata[k] = (due[k] == cyc) ? due_data[k] : {$urandom, $urandom};
    end

    // ---------------- stimulus ----------------
    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_type[k] = '0;
            d_addr[k] = '0; d_wdata[k] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic run_random(input int n);
        logic ig [2];
        logic dg [2];
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ig[k] = i_gnt[k];
                dg[k] = d_gnt[k];
            end
            step();
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 399) == 0) reset = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (!i_req[k] || ig[k]) begin
                    i_req[k] = $urandom_range(0, 1) == 1;
                    i_addr[k] = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
                end else if ($urandom_range(0, 15) == 0) begin
                    i_req[k] = 1'b0;
                end
                if (!d_req[k] || dg[k]) begin
                    d_req[k] = $urandom_range(0, 1) == 1;
                    d_we[k] = $urandom_range(0, 2) == 0;
                    d_type[k] = 3'($urandom_range(0, 7));
                    d_addr[k] = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
                    d_wdata[k] = {$urandom, $urandom};
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        idle_all();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // single load on LAT=1
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'h100; d_type[0] = 3'b011;
        @(negedge clk);
        chk("t1_d_gnt", 0, d_gnt[0], 64'd1);
        chk("t1_m_req", 0, m_req[0], 64'd1);
        chk("t1_m_addr", 0, m_addr[0], 64'h100);
        chk("t1_m_we", 0, m_we[0], 64'd0);
        step();
        d_req[0] = 1'b0;
        @(negedge clk);
        chk("t1_d_rvalid", 0, d_rvalid[0], 64'd1);
        chk("t1_d_rdata", 0, d_rdata[0], 64'hA5A5_0100_FFFF_FEFF);
        chk("t1_i_rvalid", 0, i_rvalid[0], 64'd0);
        step();

        // both ports held, LAT=1: D,I,D,I...
        do_reset();
        i_req[0] = 1'b1; i_addr[0] = 64'h400;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'h500;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("t2_d_gnt", 0, d_gnt[0], 64'(n % 2 == 0));
            chk("t2_i_gnt", 0, i_gnt[0], 64'(n % 2 == 1));
            if (n > 0) begin
                chk("t2_d_rvalid", 0, d_rvalid[0], 64'(n % 2 == 1));
                chk("t2_i_rvalid", 0, i_rvalid[0], 64'(n % 2 == 0));
            end
            step();
        end
        idle_all();
        step();
        step();

        // back-to-back stores
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_type[0] = 3'b011;
        for (int n = 0; n < 3; n++) begin
            d_addr[0] = 64'(n * 8);
            d_wdata[0] = 64'hCAFE_0000 + 64'(n);
            @(negedge clk);
            chk("t3_d_gnt", 0, d_gnt[0], 64'd1);
            chk("t3_m_we", 0, m_we[0], 64'd1);
            chk("t3_m_addr", 0, m_addr[0], 64'(n * 8));
            chk("t3_d_rvalid", 0, d_rvalid[0], 64'd0);
            step();
        end
        idle_all();
        step();

        // LAT=3 fetch, data request one cycle later waits for the return cycle
        i_req[1] = 1'b1; i_addr[1] = 64'h2000;
        @(negedge clk);
        chk("t4_i_gnt", 1, i_gnt[1], 64'd1);
        step();
        i_req[1] = 1'b0;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 64'h300;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n < 3) begin
                chk("t4_d_held", 1, d_gnt[1], 64'd0);
                chk("t4_i_rvalid_early", 1, i_rvalid[1], 64'd0);
                step();
            end else begin
                chk("t4_i_rvalid", 1, i_rvalid[1], 64'd1);
                chk("t4_i_rdata", 1, i_rdata[1], 64'hFFFF_DFFF);
                chk("t4_d_gnt", 1, d_gnt[1], 64'd1);
            end
        end
        step();
        idle_all();
        repeat (4) step();

        // reset in the middle of an outstanding LAT=3 read
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 64'h700;
        @(negedge clk);
        chk("t5_d_gnt", 1, d_gnt[1], 64'd1);
        step();
        i_req[1] = 1'b1; i_addr[1] = 64'h800;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_outs", 1, {d_gnt[1], i_gnt[1], m_req[1], d_rvalid[1]}, 64'd0);
        step();
        step();
        @(negedge clk);
        chk("t5_no_rvalid", 1, d_rvalid[1], 64'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_post_gnt", 1, d_gnt[1], 64'd1);
        chk("t5_post_rvalid", 1, d_rvalid[1], 64'd0);
        step();
        idle_all();
        step();

        run_random(3000);
        idle_all();
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
